// File: rtl/lsu_ctrl.sv
// +--------------------------------------------------------------------------+
// | lsu_ctrl : load/store sequencer between execute stage and data memory    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en_i,
  input  logic        mem_write_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        access_fault_o,
  output logic        bus_error_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q, we_q, load_valid_q, bus_error_q;
  logic [31:0]      addr_q, wdata_q, load_data_q;
  logic [3:0]       be_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        any_en, ld_f3_ok, st_f3_ok, misalign, fault, start;
  logic [31:0] wdata_d, ld_fmt_d;
  logic [3:0]  be_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Access legality is judged only in IDLE, on the instruction currently in execute.
  always_comb begin
    any_en   = mem_read_en_i | mem_write_en_i;
    ld_f3_ok = (funct3_i != 3'b011) && (funct3_i != 3'b110) && (funct3_i != 3'b111);
    st_f3_ok = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
    misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
               ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    fault    = any_en & ((mem_read_en_i & mem_write_en_i) |
                         (mem_read_en_i & ~ld_f3_ok) |
                         (mem_write_en_i & ~st_f3_ok) | misalign);
    start          = (state_q == IDLE) & any_en & ~fault;
    access_fault_o = (state_q == IDLE) & fault;
    stall_o        = start | (state_q == REQ);
  end

  always_comb begin
    wdata_d = store_data_i;
    be_d    = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_d = {4{store_data_i[7:0]}};
        be_d    = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        wdata_d = {2{store_data_i[15:0]}};
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mem_write_en_i) be_d = 4'b0000;
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_fmt_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt_d = {24'd0, ld_byte};
      3'b001:  ld_fmt_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt_d = {16'd0, ld_half};
      default: ld_fmt_d = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= mem_write_en_i;
            addr_q  <= {addr_i[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            cnt_q   <= '0;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes the access.
          if (dmem_ack_i) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) begin
              load_data_q  <= ld_fmt_d;
              load_valid_q <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            req_q       <= 1'b0;
            bus_error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign bus_error_o  = bus_error_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed self-checking bench for lsu_ctrl (TIMEOUT = 4)    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, access_fault, bus_error;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_chk  = 0;
  int n_pass = 0;

  int          n_stall, n_req;
  logic        seen_fault, seen_lv, seen_berr, fld_stable;
  logic [31:0] seen_ld, cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read_en_i  (mem_read_en),
    .mem_write_en_i (mem_write_en),
    .funct3_i       (funct3),
    .addr_i         (addr),
    .store_data_i   (store_data),
    .stall_o        (stall),
    .load_data_o    (load_data),
    .load_valid_o   (load_valid),
    .access_fault_o (access_fault),
    .bus_error_o    (bus_error),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_be_o      (dmem_be),
    .dmem_ack_i     (dmem_ack),
    .dmem_rdata_i   (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Issues one instruction and plays a memory that acks after 'waits' request cycles.
  // Returns at the completion cycle (DONE) or at once for a rejected access.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int waits, input logic [31:0] rdata);
    bit done;
    done = 0;
    n_stall = 0; n_req = 0;
    seen_fault = 0; seen_lv = 0; seen_berr = 0; fld_stable = 1;
    seen_ld = 'x;
    @(negedge clk);
    mem_read_en = rd; mem_write_en = wr; funct3 = f3; addr = a; store_data = sd;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall) n_stall++;
      if (access_fault) seen_fault = 1;
      if (dmem_req) begin
        if (n_req == 0) begin
          cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be;
        end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} !==
                     {cap_we, cap_addr, cap_wdata, cap_be}) begin
          fld_stable = 0;
        end
        n_req++;
        dmem_ack   = (n_req - 1 == waits);
        dmem_rdata = dmem_ack ? rdata : ~rdata;
      end else begin
        dmem_ack = 1'b0;
      end
      if (!stall && !dmem_req && (n_req > 0 || c == 0)) begin
        done      = 1;
        seen_lv   = load_valid;
        seen_berr = bus_error;
        seen_ld   = load_data;
      end
      if (!done) @(negedge clk);
    end
    if (!done) chk("completion_bound", 32'd0, 32'd1);
    mem_read_en = 0; mem_write_en = 0; dmem_ack = 0;
  endtask

  initial begin
    reset = 1; mem_read_en = 0; mem_write_en = 0; funct3 = 0; addr = 0; store_data = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_pulses", {29'd0, load_valid, bus_error, access_fault}, 32'd0);
    reset = 0;

    // LW, two wait cycles
    run_access(1, 0, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_be", {28'd0, cap_be}, 32'd0);
    chk("lw_we", {31'd0, cap_we}, 32'd0);
    chk("lw_stall", n_stall, 4);
    chk("lw_nreq", n_req, 3);
    chk("lw_stable", {31'd0, fld_stable}, 32'd1);
    chk("lw_valid", {31'd0, seen_lv}, 32'd1);
    chk("lw_data", seen_ld, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("lw_valid_pulse", {31'd0, load_valid}, 32'd0);

    run_access(1, 0, 3'b000, 32'h203, 0, 0, 32'h80112233);
    chk("lb_stall", n_stall, 2);
    chk("lb_data", seen_ld, 32'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h203, 0, 0, 32'h80112233);
    chk("lbu_data", seen_ld, 32'h00000080);
    run_access(1, 0, 3'b101, 32'h202, 0, 1, 32'h80112233);
    chk("lhu_data", seen_ld, 32'h00008011);
    run_access(1, 0, 3'b001, 32'h202, 0, 0, 32'h80112233);
    chk("lh_data", seen_ld, 32'hFFFF8011);
    run_access(1, 0, 3'b000, 32'h201, 0, 0, 32'h80112233);
    chk("lb1_data", seen_ld, 32'h00000022);
    run_access(1, 0, 3'b001, 32'h200, 0, 0, 32'h8011C233);
    chk("lh0_data", seen_ld, 32'hFFFFC233);

    // Stores
    run_access(0, 1, 3'b000, 32'h41, 32'h000000A5, 0, 0);
    chk("sb_we", {31'd0, cap_we}, 32'd1);
    chk("sb_addr", cap_addr, 32'h40);
    chk("sb_be", {28'd0, cap_be}, 32'b0010);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_novalid", {31'd0, seen_lv}, 32'd0);
    chk("sb_ld_hold", seen_ld, 32'hFFFFC233);
    run_access(0, 1, 3'b001, 32'h42, 32'hCAFE1234, 0, 0);
    chk("sh_be", {28'd0, cap_be}, 32'b1100);
    chk("sh_wdata", cap_wdata, 32'h12341234);
    run_access(0, 1, 3'b010, 32'h48, 32'h11223344, 1, 0);
    chk("sw_be", {28'd0, cap_be}, 32'b1111);
    chk("sw_wdata", cap_wdata, 32'h11223344);
    chk("sw_stall", n_stall, 3);

    // Rejected accesses
    run_access(1, 0, 3'b010, 32'h102, 0, 0, 0);
    chk("f_lw_mis", {31'd0, seen_fault}, 32'd1);
    chk("f_lw_stall", n_stall, 0);
    run_access(0, 1, 3'b001, 32'h1, 32'h55, 0, 0);
    chk("f_sh_mis", {31'd0, seen_fault}, 32'd1);
    run_access(1, 0, 3'b011, 32'h100, 0, 0, 0);
    chk("f_ld011", {31'd0, seen_fault}, 32'd1);
    chk("f_ld011_stall", n_stall, 0);
    run_access(0, 1, 3'b100, 32'h100, 0, 0, 0);
    chk("f_st100", {31'd0, seen_fault}, 32'd1);
    run_access(1, 1, 3'b010, 32'h100, 0, 0, 0);
    chk("f_both", {31'd0, seen_fault}, 32'd1);
    @(negedge clk); #1;
    chk("f_noreq", {31'd0, dmem_req}, 32'd0);
    chk("f_ld_hold", load_data, 32'hFFFFC233);

    // Timeout: memory never acks
    run_access(1, 0, 3'b010, 32'h300, 0, 1000, 0);
    chk("to_nreq", n_req, 4);
    chk("to_stall", n_stall, 5);
    chk("to_berr", {31'd0, seen_berr}, 32'd1);
    chk("to_novalid", {31'd0, seen_lv}, 32'd0);
    chk("to_ld_hold", seen_ld, 32'hFFFFC233);
    @(negedge clk); #1;
    chk("to_idle", {30'd0, bus_error, stall}, 32'd0);

    // Reset while a request is outstanding, then a late ack
    @(negedge clk);
    mem_read_en = 1; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk); #1;
    chk("rq_req", {31'd0, dmem_req}, 32'd1);
    reset = 1; mem_read_en = 0;
    @(negedge clk); #1;
    chk("rq_rst_req", {31'd0, dmem_req}, 32'd0);
    reset = 0; dmem_ack = 1; dmem_rdata = 32'h00000055;
    @(negedge clk); #1;
    chk("rq_late_ack", {29'd0, dmem_req, load_valid, stall}, 32'd0);
    dmem_ack = 0;
    run_access(1, 0, 3'b010, 32'h504, 0, 0, 32'hCAFEF00D);
    chk("rq_after_stall", n_stall, 2);
    chk("rq_after_data", seen_ld, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
